// File: rtl/tt_add_accum.sv
// rtl/tt_add_accum.sv - handshaked add/sub/accumulate unit with registered result
// One-deep output register; in_ready follows the standard skid-less pipeline rule.
module tt_add_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SATURATE  = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] acc_cnt
);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $fatal(1, "tt_add_accum: WIDTH must be >= 2");
    end
    if (ACC_WIDTH < WIDTH + 1) begin : g_bad_acc_width
      $fatal(1, "tt_add_accum: ACC_WIDTH must be >= WIDTH+1");
    end
  endgenerate

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  mode_e                 mode_s;
  logic                  accept;
  logic [ACC_WIDTH-1:0]  a_ext;
  logic [ACC_WIDTH-1:0]  b_ext;
  logic [ACC_WIDTH-1:0]  add_sum;
  logic [ACC_WIDTH-1:0]  sub_diff;
  logic [ACC_WIDTH:0]    acc_sum;

  logic                  out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]  result_q, result_d;
  logic                  ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  assign mode_s   = mode_e'(mode);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign a_ext    = ACC_WIDTH'(op_a);
  assign b_ext    = ACC_WIDTH'(op_b);
  // ACC_WIDTH >= WIDTH+1 guarantees the plain sum never loses a carry.
  assign add_sum  = a_ext + b_ext;
  assign sub_diff = a_ext - b_ext;
  assign acc_sum  = {1'b0, acc_q} + {1'b0, a_ext} + {1'b0, b_ext};

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      case (mode_s)
        MODE_ADD: begin
          result_d = add_sum;
          ovf_d    = 1'b0;
        end
        MODE_SUB: begin
          result_d = sub_diff;
          ovf_d    = (op_a < op_b);
        end
        MODE_ACC: begin
          if (acc_sum[ACC_WIDTH]) begin
            ovf_d = 1'b1;
            acc_d = (SATURATE != 0) ? ACC_MAX : acc_sum[ACC_WIDTH-1:0];
          end else begin
            ovf_d = 1'b0;
            acc_d = acc_sum[ACC_WIDTH-1:0];
          end
          result_d = acc_d;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          result_d = '0;
          ovf_d    = 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
        end
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign acc_cnt   = cnt_q;

endmodule
